// File: rtl/connect4_board_engine.sv
// connect4_board_engine
// Holds the Connect-4 board and services one drop request at a time for the
// turn controller. A request places a piece in the lowest free row of the
// selected column and then scans the four line directions through that cell.
//
// Ports:
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_verify, i_player,     drop request, sampled only while idle
//   i_column
//   i_clear                 empty the board (idle only)
//   o_busy                  request in progress
//   o_done                  one-cycle result strobe
//   o_valid, o_win          result of the last request, held until the next one
//   o_full                  every cell occupied
//   i_rd_row, i_rd_col,     combinational display read port
//   o_rd_cell               (00 empty, 01 J1, 10 J2; 00 when out of range)
//
// state  | meaning
// IDLE   | waiting for clear or verify
// PLACE  | validate the column, write the piece
// CHECK  | scan one direction per cycle (horizontal, vertical, diag /, diag \)
// DONE   | result strobe, back to IDLE
module connect4_board_engine #(
  parameter int ROWS = 6,
  parameter int COLS = 7
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_verify,
  input  logic       i_player,
  input  logic [2:0] i_column,
  input  logic       i_clear,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_valid,
  output logic       o_win,
  output logic       o_full,
  input  logic [2:0] i_rd_row,
  input  logic [2:0] i_rd_col,
  output logic [1:0] o_rd_cell
);

  localparam logic [2:0] ROWS_L  = 3'(ROWS);
  localparam logic [2:0] COLS_L  = 3'(COLS);
  localparam logic [5:0] CELLS_L = 6'(ROWS * COLS);

  typedef enum logic [1:0] {S_IDLE, S_PLACE, S_CHECK, S_DONE} state_t;

  state_t     r_state;
  logic [1:0] r_cell   [ROWS][COLS];
  logic [2:0] r_height [COLS];
  logic [5:0] r_pieces;
  logic       r_player;
  logic [2:0] r_col;
  logic [2:0] r_row;
  logic [1:0] r_dir;
  logic       r_valid;
  logic       r_win;
  logic       r_busy;
  logic       r_done;

  logic [1:0] w_code;
  logic       w_dir_win;

  assign w_code  = r_player ? 2'b10 : 2'b01;
  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_valid = r_valid;
  assign o_win   = r_win;
  assign o_full  = (r_pieces == CELLS_L);

  always_comb begin
    o_rd_cell = 2'b00;
    if (i_rd_row < ROWS_L && i_rd_col < COLS_L)
      o_rd_cell = r_cell[i_rd_row][i_rd_col];
  end

  // The four length-4 windows through the placed cell along r_dir: window k
  // starts k steps behind the placed cell. Out-of-bounds cells kill a window.
  always_comb begin : dir_eval
    int   dr, dc, rr, cc;
    logic ok;
    w_dir_win = 1'b0;
    dr = 0;
    dc = 1;
    case (r_dir)
      2'd0:    begin dr = 0; dc = 1;  end
      2'd1:    begin dr = 1; dc = 0;  end
      2'd2:    begin dr = 1; dc = 1;  end
      default: begin dr = 1; dc = -1; end
    endcase
    for (int k = 0; k < 4; k++) begin
      ok = 1'b1;
      for (int j = 0; j < 4; j++) begin
        rr = int'(r_row) + (j - k) * dr;
        cc = int'(r_col) + (j - k) * dc;
        if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS)
          ok = 1'b0;
        else if (r_cell[rr[2:0]][cc[2:0]] != w_code)
          ok = 1'b0;
      end
      if (ok)
        w_dir_win = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_cell[r][c] <= 2'b00;
      for (int c = 0; c < COLS; c++)
        r_height[c] <= 3'd0;
      r_pieces <= 6'd0;
      r_player <= 1'b0;
      r_col    <= 3'd0;
      r_row    <= 3'd0;
      r_dir    <= 2'd0;
      r_valid  <= 1'b0;
      r_win    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // clear wins over a simultaneous verify, which is dropped
          if (i_clear) begin
            for (int r = 0; r < ROWS; r++)
              for (int c = 0; c < COLS; c++)
                r_cell[r][c] <= 2'b00;
            for (int c = 0; c < COLS; c++)
              r_height[c] <= 3'd0;
            r_pieces <= 6'd0;
            r_valid  <= 1'b0;
            r_win    <= 1'b0;
          end else if (i_verify) begin
            r_player <= i_player;
            r_col    <= i_column;
            r_busy   <= 1'b1;
            r_state  <= S_PLACE;
          end
        end
        S_PLACE: begin
          if (r_col >= COLS_L) begin
            r_valid <= 1'b0;
            r_win   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else if (r_height[r_col] == ROWS_L) begin
            r_valid <= 1'b0;
            r_win   <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cell[r_height[r_col]][r_col] <= w_code;
            r_row           <= r_height[r_col];
            r_height[r_col] <= r_height[r_col] + 3'd1;
            r_pieces        <= r_pieces + 6'd1;
            r_valid         <= 1'b1;
            r_win           <= 1'b0;
            r_dir           <= 2'd0;
            r_state         <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_dir_win)
            r_win <= 1'b1;
          r_dir <= r_dir + 2'd1;
          if (r_dir == 2'd3) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_connect4_board_engine.sv
// Self-checking bench for connect4_board_engine: directed scenarios plus a
// random drop sequence, all checked against a plain array model of the board.
module tb_connect4_board_engine;

  logic       clk;
  logic       rst;
  logic       verify;
  logic       player;
  logic [2:0] column;
  logic       clear;
  logic       busy, done, valid, win, full;
  logic [2:0] rd_row, rd_col;
  logic [1:0] rd_cell;

  int n_assert = 0;
  int n_fail   = 0;

  // reference board: 0 empty, 1 J1, 2 J2
  int bd [0:5][0:6];
  int ht [0:6];
  int pieces;

  connect4_board_engine dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_verify  (verify),
    .i_player  (player),
    .i_column  (column),
    .i_clear   (clear),
    .o_busy    (busy),
    .o_done    (done),
    .o_valid   (valid),
    .o_win     (win),
    .o_full    (full),
    .i_rd_row  (rd_row),
    .i_rd_col  (rd_col),
    .o_rd_cell (rd_cell)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        bd[r][c] = 0;
    for (int c = 0; c < 7; c++)
      ht[c] = 0;
    pieces = 0;
  endfunction

  // longest run of `code` through (r,c) in each direction, counted outward
  function automatic bit model_win(input int r, input int c, input int code);
    int drs [4] = '{0, 1, 1, 1};
    int dcs [4] = '{1, 0, 1, -1};
    for (int d = 0; d < 4; d++) begin
      int n = 1;
      for (int s = -1; s <= 1; s += 2) begin
        int rr = r + s * drs[d];
        int cc = c + s * dcs[d];
        while (rr >= 0 && rr < 6 && cc >= 0 && cc < 7 && bd[rr][cc] == code) begin
          n++;
          rr += s * drs[d];
          cc += s * dcs[d];
        end
      end
      if (n >= 4) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic sweep(input string tag);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++) begin
        rd_row = 3'(r);
        rd_col = 3'(c);
        #1;
        check(tag, rd_cell, bd[r][c]);
      end
    rd_row = 3'd7; rd_col = 3'd0; #1;
    check({tag, "_oor_row"}, rd_cell, 0);
    rd_row = 3'd0; rd_col = 3'd7; #1;
    check({tag, "_oor_col"}, rd_cell, 0);
  endtask

  // One request; pulse_cyc > 0 raises verify for one cycle that many
  // cycles after acceptance (the DUT must ignore it while busy).
  task automatic drop(input bit p, input int c, input int pulse_cyc, output bit ew);
    bit ev;
    int r, cyc, code;
    ev   = 1'b0;
    ew   = 1'b0;
    code = p ? 2 : 1;
    if (c < 7) ev = (ht[c] < 6);
    if (ev) begin
      r = ht[c];
      bd[r][c] = code;
      ht[c]++;
      pieces++;
      ew = model_win(r, c, code);
      rd_row = 3'(r);
      rd_col = 3'(c);
    end
    @(negedge clk);
    verify = 1'b1;
    player = p;
    column = 3'(c);
    check("idle_busy", busy, 0);
    @(negedge clk);
    verify = 1'b0;
    check("place_busy", busy, 1);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      verify = (cyc == pulse_cyc);
      if (cyc == 2 && ev) begin
        check("valid_t2", valid, 1);
        check("cell_t2", rd_cell, code);
      end
    end
    verify = 1'b0;
    check("done_latency", cyc, ev ? 6 : 2);
    check("done_valid", valid, ev);
    check("done_win", win, ew);
    check("done_full", full, pieces == 42);
    check("done_busy", busy, 1);
    @(negedge clk);
    check("after_done", done, 0);
    check("after_busy", busy, 0);
    check("hold_valid", valid, ev);
    check("hold_win", win, ew);
  endtask

  task automatic do_clear();
    int nd;
    @(negedge clk);
    clear  = 1'b1;
    verify = 1'b1;
    column = 3'd0;
    @(negedge clk);
    clear  = 1'b0;
    verify = 1'b0;
    model_clear();
    check("clear_busy", busy, 0);
    check("clear_valid", valid, 0);
    check("clear_win", win, 0);
    check("clear_full", full, 0);
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("clear_no_done", nd, 0);
  endtask

  initial begin
    bit w;
    int nd;
    rst = 1'b1; verify = 1'b0; player = 1'b0; column = 3'd0; clear = 1'b0;
    rd_row = 3'd0; rd_col = 3'd0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", valid, 0);
    check("rst_win", win, 0);
    check("rst_full", full, 0);
    rst = 1'b0;
    @(negedge clk);
    sweep("rst_cell");

    // vertical four for J1 in column 3, J2 answering in column 0
    for (int i = 0; i < 4; i++) begin
      drop(1'b0, 3, 0, w);
      check("vert_win", win, i == 3);
      if (i < 3) drop(1'b1, 0, 0, w);
    end
    rd_row = 3'd3; rd_col = 3'd3; #1;
    check("cell_3_3", rd_cell, 1);

    // clear with verify in the same cycle: board empty, no done
    do_clear();
    sweep("cleared");

    // column 5 overflow on the seventh drop
    for (int i = 0; i < 7; i++) begin
      drop(1'(i % 2), 5, 0, w);
      check("col5_valid", valid, i < 6);
    end
    sweep("col5_board");

    // out-of-range column, then J2 diagonal finished at its top end
    do_clear();
    drop(1'b0, 7, 0, w);
    check("col7_valid", valid, 0);
    drop(1'b1, 0, 0, w);
    drop(1'b0, 1, 0, w); drop(1'b1, 1, 0, w);
    drop(1'b0, 2, 0, w); drop(1'b0, 2, 0, w); drop(1'b1, 2, 0, w);
    drop(1'b0, 3, 0, w); drop(1'b0, 3, 0, w); drop(1'b0, 3, 0, w);
    check("diag_pre", win, 0);
    drop(1'b1, 3, 0, w);
    check("diag_end_win", win, 1);

    // same diagonal completed from the middle, with a verify pulse during CHECK
    do_clear();
    drop(1'b1, 0, 0, w);
    drop(1'b0, 1, 0, w); drop(1'b1, 1, 0, w);
    drop(1'b0, 2, 0, w); drop(1'b0, 2, 0, w);
    drop(1'b0, 3, 0, w); drop(1'b0, 3, 0, w); drop(1'b0, 3, 0, w);
    drop(1'b1, 3, 0, w);
    check("diag_mid_pre", win, 0);
    drop(1'b1, 2, 3, w);
    check("diag_mid_win", win, 1);
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("pulse_ignored", nd, 0);

    // random play, including full and out-of-range columns
    do_clear();
    for (int i = 0; i < 60; i++)
      drop(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0, w);
    sweep("random_board");

    // fill the board in a pattern with no four in a row
    do_clear();
    for (int c = 0; c < 7; c++)
      for (int r = 0; r < 6; r++) begin
        drop(1'(((r >> 1) + c) % 2), c, 0, w);
        check("fill_nowin", win, 0);
      end
    check("fill_full", full, 1);
    sweep("full_board");
    drop(1'b0, 0, 0, w);
    check("full_reject", valid, 0);

    // reset in the middle of CHECK
    do_clear();
    @(negedge clk);
    verify = 1'b1; player = 1'b0; column = 3'd4;
    @(negedge clk);
    verify = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_valid", valid, 1);
    rst = 1'b1;
    @(negedge clk);
    model_clear();
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_valid", valid, 0);
    check("abort_win", win, 0);
    check("abort_full", full, 0);
    rd_row = 3'd0; rd_col = 3'd4; #1;
    check("abort_cell", rd_cell, 0);
    rst = 1'b0;
    nd = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
